// File: rtl/sram_pkg.sv
// sram_pkg: shared types and the bit-level write-mask merge used by the 1RW macro models.
package sram_pkg;

   typedef enum logic {
      RDW_READ_FIRST  = 1'b0,
      RDW_WRITE_FIRST = 1'b1
   } rdw_mode_e;

   typedef enum logic {
      INIT  = 1'b0,
      READY = 1'b1
   } init_state_e;

   // Active-low enable: a set bweb bit keeps the stored bit, a clear one takes the new bit.
   function automatic logic lane_merge(input logic old_b, input logic new_b, input logic bweb_b);
      return bweb_b ? old_b : new_b;
   endfunction

endpackage

// File: rtl/sram_init_seq.sv
// sram_init_seq: INIT/READY sequencer that sweeps every word once after reset.
// While sweeping it owns the array write port and holds BUSY high.
module sram_init_seq
   import sram_pkg::*;
#(
   parameter int DEPTH      = 256,
   parameter int INIT_SWEEP = 1,
   localparam int ADDR_W    = $clog2(DEPTH)
) (
   input  logic              i_clk,
   input  logic              i_rst_n,
   output logic              o_busy,
   output logic [ADDR_W-1:0] o_sweep_addr,
   output logic              o_sweep_we
);

   localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

   init_state_e       r_state;
   init_state_e       w_state_nxt;
   logic [ADDR_W-1:0] r_cnt;
   logic [ADDR_W-1:0] w_cnt_nxt;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state <= (INIT_SWEEP != 0) ? INIT : READY;
         r_cnt   <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      if (r_state == INIT) begin
         if (r_cnt == LAST_ADDR) begin
            w_state_nxt = READY;
            w_cnt_nxt   = '0;
         end else begin
            w_cnt_nxt = r_cnt + 1'b1;
         end
      end
   end

   assign o_busy       = (r_state == INIT);
   assign o_sweep_we   = (r_state == INIT);
   assign o_sweep_addr = r_cnt;

endmodule

// File: rtl/sram_1rw_param.sv
// sram_1rw_param: parametrised 1RW behavioural SRAM with lane write mask, RD_LAT 1/2 and init sweep.
// Define SRAM_TIMING_CHECK_EN for a specify block whose NOTIFIER corrupts O and the written word.
module sram_1rw_param
   import sram_pkg::*;
#(
   parameter int               DEPTH      = 256,
   parameter int               WIDTH      = 32,
   parameter int               MASK_GRAN  = 8,
   parameter int               RD_LAT     = 1,
   parameter int               RDW_MODE   = 0,
   parameter int               INIT_SWEEP = 1,
   parameter logic [WIDTH-1:0] INIT_VAL   = '0,
   localparam int              ADDR_W     = $clog2(DEPTH),
   localparam int              LANES      = WIDTH / MASK_GRAN
) (
   input  logic              CE,
   input  logic              RSTB,
   input  logic              CSB,
   input  logic              WEB,
   input  logic              OEB,
   input  logic [LANES-1:0]  BWEB,
   input  logic [ADDR_W-1:0] A,
   input  logic [WIDTH-1:0]  I,
   output logic [WIDTH-1:0]  O,
   output logic              O_VALID,
   output logic              BUSY
);

   localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W + 1)'(DEPTH);
   localparam rdw_mode_e       RDW     = (RDW_MODE != 0) ? RDW_WRITE_FIRST : RDW_READ_FIRST;

   if (WIDTH % MASK_GRAN != 0) begin : g_bad_gran
      $error("sram_1rw_param: WIDTH must be a multiple of MASK_GRAN");
   end
   if (RD_LAT != 1 && RD_LAT != 2) begin : g_bad_lat
      $error("sram_1rw_param: RD_LAT must be 1 or 2");
   end

   logic [WIDTH-1:0]  r_mem [DEPTH];
   logic [WIDTH-1:0]  r_o;
   logic              r_o_vld;
   logic              w_busy;
   logic              w_sweep_we;
   logic [ADDR_W-1:0] w_sweep_addr;
   logic              w_re;
   logic              w_we;
   logic              w_in_range;
   logic              w_viol;
   logic [WIDTH-1:0]  w_old;
   logic [WIDTH-1:0]  w_merged;
   logic [WIDTH-1:0]  w_rd_data;

   sram_init_seq #(
      .DEPTH      (DEPTH),
      .INIT_SWEEP (INIT_SWEEP)
   ) u_init_seq (
      .i_clk        (CE),
      .i_rst_n      (RSTB),
      .o_busy       (w_busy),
      .o_sweep_addr (w_sweep_addr),
      .o_sweep_we   (w_sweep_we)
   );

   assign w_re       = ~CSB & ~OEB & ~w_busy;
   assign w_we       = ~CSB & ~WEB & ~w_busy;
   assign w_in_range = ({1'b0, A} < DEPTH_L);
   assign w_old      = w_in_range ? r_mem[A] : '0;

   always_comb begin
      w_merged = w_old;
      for (int b = 0; b < WIDTH; b++) begin
         w_merged[b] = lane_merge(w_old[b], I[b], BWEB[b / MASK_GRAN]);
      end
   end

   // Out-of-range reads return zero because w_old is already forced to zero there.
   assign w_rd_data = (w_we && w_in_range && RDW == RDW_WRITE_FIRST) ? w_merged : w_old;

`ifdef SRAM_TIMING_CHECK_EN
   reg   NOTIFIER;
   logic r_notifier_q;

   always_ff @(posedge CE) r_notifier_q <= NOTIFIER;
   assign w_viol = (NOTIFIER !== r_notifier_q);

   specify
      $setuphold(posedge CE, A,    0, 0, NOTIFIER);
      $setuphold(posedge CE, I,    0, 0, NOTIFIER);
      $setuphold(posedge CE, BWEB, 0, 0, NOTIFIER);
      $setuphold(posedge CE, CSB,  0, 0, NOTIFIER);
      $setuphold(posedge CE, WEB,  0, 0, NOTIFIER);
      $setuphold(posedge CE, OEB,  0, 0, NOTIFIER);
      (CE *> O) = 0;
   endspecify
`else
   assign w_viol = 1'b0;
`endif

   // Array is never reset; the sweep takes priority over user writes while BUSY.
   always_ff @(posedge CE) begin
      if (w_sweep_we) begin
         r_mem[w_sweep_addr] <= INIT_VAL;
      end else if (w_we && w_in_range) begin
         r_mem[A] <= w_viol ? 'x : w_merged;
      end
   end

   if (RD_LAT == 2) begin : g_lat2
      logic [WIDTH-1:0] r_data_p1;
      logic             r_vld_p1;

      always_ff @(posedge CE or negedge RSTB) begin
         if (!RSTB) begin
            r_data_p1 <= '0;
            r_vld_p1  <= 1'b0;
            r_o       <= '0;
            r_o_vld   <= 1'b0;
         end else begin
            r_vld_p1 <= w_re;
            r_o_vld  <= r_vld_p1;
            if (w_viol) begin
               r_data_p1 <= 'x;
               r_o       <= 'x;
            end else begin
               if (w_re)     r_data_p1 <= w_rd_data;
               if (r_vld_p1) r_o       <= r_data_p1;
            end
         end
      end
   end else begin : g_lat1
      always_ff @(posedge CE or negedge RSTB) begin
         if (!RSTB) begin
            r_o     <= '0;
            r_o_vld <= 1'b0;
         end else begin
            r_o_vld <= w_re;
            if (w_viol)    r_o <= 'x;
            else if (w_re) r_o <= w_rd_data;
         end
      end
   end

   assign O       = r_o;
   assign O_VALID = r_o_vld;
   assign BUSY    = w_busy;

endmodule

// File: tb/tb_sram_1rw_param.sv
// tb_sram_1rw_param: two configurations (256x32 RD_LAT=1 read-first, 200x32 RD_LAT=2 write-first)
// checked against a reference array model through per-instance expected-read queues.
module tb_sram_1rw_param;

   localparam logic [31:0] INIT_A = 32'hA5A5A5A5;
   localparam logic [31:0] INIT_B = 32'h5A5A0F0F;

   typedef struct {
      logic [31:0] d;
      int          due;
   } exp_t;

   logic CE = 1'b0;
   always #5 CE = ~CE;

   int cyc = 0;
   always @(posedge CE) cyc <= cyc + 1;

   logic        a_rstb, a_csb, a_web, a_oeb, a_ovld, a_busy;
   logic [3:0]  a_bweb;
   logic [7:0]  a_addr;
   logic [31:0] a_i, a_o;
   logic        b_rstb, b_csb, b_web, b_oeb, b_ovld, b_busy;
   logic [3:0]  b_bweb;
   logic [7:0]  b_addr;
   logic [31:0] b_i, b_o;

   sram_1rw_param #(
      .DEPTH(256), .WIDTH(32), .MASK_GRAN(8), .RD_LAT(1), .RDW_MODE(0),
      .INIT_SWEEP(1), .INIT_VAL(INIT_A)
   ) dut_a (
      .CE(CE), .RSTB(a_rstb), .CSB(a_csb), .WEB(a_web), .OEB(a_oeb), .BWEB(a_bweb),
      .A(a_addr), .I(a_i), .O(a_o), .O_VALID(a_ovld), .BUSY(a_busy)
   );

   sram_1rw_param #(
      .DEPTH(200), .WIDTH(32), .MASK_GRAN(8), .RD_LAT(2), .RDW_MODE(1),
      .INIT_SWEEP(1), .INIT_VAL(INIT_B)
   ) dut_b (
      .CE(CE), .RSTB(b_rstb), .CSB(b_csb), .WEB(b_web), .OEB(b_oeb), .BWEB(b_bweb),
      .A(b_addr), .I(b_i), .O(b_o), .O_VALID(b_ovld), .BUSY(b_busy)
   );

   int          checks = 0;
   int          errors = 0;
   logic [31:0] ma [256];
   logic [31:0] mb [200];
   exp_t        qa [$];
   exp_t        qb [$];
   exp_t        ea, eb;

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h expected=%h", tag, act, exp);
      end
   endtask

   // One access per call, driven at the falling edge; updates the model and queues the read.
   task automatic acc(input int s, input logic csb, input logic web, input logic oeb,
                      input logic [3:0] bweb, input logic [7:0] a, input logic [31:0] d);
      logic [31:0] old_w, new_w, rd;
      int          depth;
      exp_t        e;
      @(negedge CE);
      if (s == 0) begin
         a_csb = csb; a_web = web; a_oeb = oeb; a_bweb = bweb; a_addr = a; a_i = d;
      end else begin
         b_csb = csb; b_web = web; b_oeb = oeb; b_bweb = bweb; b_addr = a; b_i = d;
      end
      depth = (s == 0) ? 256 : 200;
      old_w = 32'h0;
      if (int'(a) < depth) old_w = (s == 0) ? ma[a] : mb[a];
      new_w = old_w;
      for (int k = 0; k < 4; k++) if (!bweb[k]) new_w[k*8 +: 8] = d[k*8 +: 8];
      if (!csb && !oeb) begin
         rd    = (s == 1 && !web && int'(a) < depth) ? new_w : old_w;
         e.d   = rd;
         e.due = cyc + ((s == 0) ? 1 : 2);
         if (s == 0) qa.push_back(e); else qb.push_back(e);
      end
      if (!csb && !web && int'(a) < depth) begin
         if (s == 0) ma[a] = new_w; else mb[a] = new_w;
      end
   endtask

   task automatic idle(input int s, input int n);
      for (int k = 0; k < n; k++) acc(s, 1'b1, 1'b1, 1'b1, 4'hF, 8'h00, 32'h0);
   endtask

   always @(negedge CE) begin
      if (a_ovld) begin
         if (qa.size() == 0) chk("a_vld_unexpected", 32'(a_ovld), 32'd0);
         else begin
            ea = qa.pop_front();
            chk("a_rdata", a_o, ea.d);
            chk("a_rd_cycle", 32'(cyc), 32'(ea.due));
         end
      end else if (qa.size() > 0 && qa[0].due < cyc) begin
         chk("a_vld_missing", 32'(a_ovld), 32'd1);
         void'(qa.pop_front());
      end
   end

   always @(negedge CE) begin
      if (b_ovld) begin
         if (qb.size() == 0) chk("b_vld_unexpected", 32'(b_ovld), 32'd0);
         else begin
            eb = qb.pop_front();
            chk("b_rdata", b_o, eb.d);
            chk("b_rd_cycle", 32'(cyc), 32'(eb.due));
         end
      end else if (qb.size() > 0 && qb[0].due < cyc) begin
         chk("b_vld_missing", 32'(b_ovld), 32'd1);
         void'(qb.pop_front());
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog checks=%0d errors=%0d", checks, errors);
      $fatal(1, "timeout");
   end

   initial begin
      int n;
      a_rstb = 1'b0; a_csb = 1'b1; a_web = 1'b1; a_oeb = 1'b1; a_bweb = 4'hF; a_addr = '0; a_i = '0;
      b_rstb = 1'b0; b_csb = 1'b1; b_web = 1'b1; b_oeb = 1'b1; b_bweb = 4'hF; b_addr = '0; b_i = '0;
      repeat (3) @(negedge CE);
      chk("a_rst_o", a_o, 32'h0);
      chk("a_rst_vld", 32'(a_ovld), 32'd0);
      chk("a_rst_busy", 32'(a_busy), 32'd1);
      chk("b_rst_busy", 32'(b_busy), 32'd1);

      // Sweep of the 256-word instance, with a write attempted while BUSY.
      a_rstb = 1'b1;
      n = 0;
      while (a_busy && n < 1000) begin
         n++;
         if (n == 10) begin
            a_csb = 1'b0; a_web = 1'b0; a_bweb = 4'h0; a_addr = 8'hFF; a_i = 32'h12345678;
         end else begin
            a_csb = 1'b1; a_web = 1'b1; a_bweb = 4'hF;
         end
         @(negedge CE);
      end
      chk("a_busy_cycles", 32'(n), 32'd256);
      for (int k = 0; k < 256; k++) ma[k] = INIT_A;
      acc(0, 1'b0, 1'b1, 1'b0, 4'hF, 8'hFF, 32'h0);
      acc(0, 1'b0, 1'b1, 1'b0, 4'hF, 8'h00, 32'h0);

      // Lane-masked writes.
      acc(0, 1'b0, 1'b0, 1'b1, 4'b0000, 8'd3, 32'h11223344);
      acc(0, 1'b0, 1'b0, 1'b1, 4'b1010, 8'd3, 32'hFFFFFFFF);
      acc(0, 1'b0, 1'b1, 1'b0, 4'hF, 8'd3, 32'h0);
      acc(0, 1'b0, 1'b0, 1'b1, 4'b1111, 8'd3, 32'h0BADF00D);
      idle(0, 3);
      chk("a_hold_o", a_o, 32'h11FF33FF);
      chk("a_hold_vld", 32'(a_ovld), 32'd0);

      // Deselected access must neither write nor read.
      acc(0, 1'b1, 1'b0, 1'b0, 4'h0, 8'd3, 32'h0);
      acc(0, 1'b0, 1'b1, 1'b0, 4'hF, 8'd3, 32'h0);

      // Read-during-write, read-first instance.
      acc(0, 1'b0, 1'b0, 1'b1, 4'h0, 8'd7, 32'hDEADBEEF);
      acc(0, 1'b0, 1'b0, 1'b0, 4'h0, 8'd7, 32'h0);
      acc(0, 1'b0, 1'b1, 1'b0, 4'hF, 8'd7, 32'h0);
      idle(0, 3);

      // 200-word instance: sweep interrupted by reset at word 100, then full sweep.
      b_rstb = 1'b1;
      n = 0;
      while (b_busy && n < 100) begin
         n++;
         @(negedge CE);
      end
      b_rstb = 1'b0;
      #1;
      chk("b_midrst_busy", 32'(b_busy), 32'd1);
      chk("b_midrst_o", b_o, 32'h0);
      chk("b_midrst_vld", 32'(b_ovld), 32'd0);
      @(negedge CE);
      b_rstb = 1'b1;
      n = 0;
      while (b_busy && n < 1000) begin
         n++;
         @(negedge CE);
      end
      chk("b_busy_cycles", 32'(n), 32'd200);
      for (int k = 0; k < 200; k++) mb[k] = INIT_B;

      // Read-during-write, write-first instance.
      acc(1, 1'b0, 1'b0, 1'b1, 4'h0, 8'd7, 32'hDEADBEEF);
      acc(1, 1'b0, 1'b0, 1'b0, 4'h0, 8'd7, 32'h0);
      acc(1, 1'b0, 1'b1, 1'b0, 4'hF, 8'd7, 32'h0);
      acc(1, 1'b0, 1'b0, 1'b0, 4'b0101, 8'd8, 32'hCCDDEEFF);

      // Back-to-back reads through the two-stage pipeline.
      acc(1, 1'b0, 1'b0, 1'b1, 4'h0, 8'd1, 32'h11110001);
      acc(1, 1'b0, 1'b0, 1'b1, 4'h0, 8'd2, 32'h22220002);
      acc(1, 1'b0, 1'b0, 1'b1, 4'h0, 8'd3, 32'h33330003);
      acc(1, 1'b0, 1'b1, 1'b0, 4'hF, 8'd1, 32'h0);
      acc(1, 1'b0, 1'b1, 1'b0, 4'hF, 8'd2, 32'h0);
      acc(1, 1'b0, 1'b1, 1'b0, 4'hF, 8'd3, 32'h0);
      idle(1, 4);
      chk("b_hold_o", b_o, 32'h33330003);
      chk("b_hold_vld", 32'(b_ovld), 32'd0);

      // Out-of-range address: write dropped, read returns zero, no aliasing.
      acc(1, 1'b0, 1'b0, 1'b1, 4'h0, 8'd210, 32'hCAFEF00D);
      acc(1, 1'b0, 1'b1, 1'b0, 4'hF, 8'd210, 32'h0);
      acc(1, 1'b0, 1'b1, 1'b0, 4'hF, 8'd10, 32'h0);
      acc(1, 1'b0, 1'b1, 1'b0, 4'hF, 8'd82, 32'h0);
      acc(1, 1'b0, 1'b1, 1'b0, 4'hF, 8'd0, 32'h0);
      acc(1, 1'b0, 1'b1, 1'b0, 4'hF, 8'd199, 32'h0);
      acc(1, 1'b0, 1'b1, 1'b0, 4'hF, 8'd8, 32'h0);
      idle(1, 5);

      chk("a_queue_drained", 32'(qa.size()), 32'd0);
      chk("b_queue_drained", 32'(qb.size()), 32'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
